cpu_ctrl_fsm: RTL and testbench

- Multi-cycle control sequencer for the Lab CPU.
- Sits directly upstream of the program counter and drives its pc_ld and pc_inc enables. It also drives the instruction-register load, memory read/write strobes and register-file write enable.
- Fetches each instruction over a ready-handshake memory port, decodes opcode ir_in[15:12], and sequences execute/writeback.
- A memory stall watchdog halts the core on a hung access.

---
 rtl/cpu_ctrl_fsm.sv | 182 ++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the Lab CPU: fetch over a ready-handshake
// memory port, decode ir_in[15:12], sequence execute/writeback, watchdog on hung accesses.
module cpu_ctrl_fsm #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir_in,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        ir_ld,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_we,
  output logic        wb_sel,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic [1:0]  err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'b000,
    S_DECODE  = 3'b001,
    S_EXEC    = 3'b010,
    S_MEMWAIT = 3'b011,
    S_WB      = 3'b100,
    S_HALT    = 3'b101
  } state_e;

  typedef enum logic [1:0] {
    E_NONE    = 2'b00,
    E_ILLEGAL = 2'b01,
    E_TIMEOUT = 2'b10
  } err_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  err_e             err_q, err_d;
  logic [3:0]       opcode;
  logic             wait_expired;
  logic             unused_ir;

  assign opcode       = ir_in[15:12];
  assign unused_ir    = ^ir_in[11:0];
  assign wait_expired = (cnt_q == WAIT_LIM);

  // NOTE: every variable driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_rdy) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_HALT;
          err_d   = E_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_NOP:                         state_d = S_FETCH;
          OP_ADD, OP_SUB, OP_JMP, OP_BEQ: state_d = S_EXEC;
          OP_LD, OP_ST:                   state_d = S_MEMWAIT;
          OP_HALT: begin
            state_d = S_HALT;
            err_d   = E_NONE;
          end
          default: begin
            state_d = S_HALT;
            err_d   = E_ILLEGAL;
          end
        endcase
      end
      S_EXEC: state_d = S_FETCH;
      S_MEMWAIT: begin
        if (mem_rdy) begin
          state_d = (opcode == OP_LD) ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          state_d = S_HALT;
          err_d   = E_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // The watchdog window restarts on each fresh entry into a waiting state.
    if ((state_d == S_FETCH || state_d == S_MEMWAIT) && state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= E_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Strobes are forced low while reset is held so an aborted access never completes.
  always_comb begin
    pc_ld  = 1'b0;
    pc_inc = 1'b0;
    ir_ld  = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    reg_we = 1'b0;
    wb_sel = 1'b0;
    alu_op = 3'b000;
    halted = 1'b0;
    if (reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_rd = 1'b1;
          ir_ld  = mem_rdy;
          pc_inc = mem_rdy;
        end
        S_EXEC: begin
          unique case (opcode)
            OP_ADD: begin
              alu_op = 3'b001;
              reg_we = 1'b1;
            end
            OP_SUB: begin
              alu_op = 3'b010;
              reg_we = 1'b1;
            end
            OP_JMP: pc_ld = 1'b1;
            OP_BEQ: begin
              alu_op = 3'b011;
              pc_ld  = zero;
            end
            default: ;
          endcase
        end
        S_MEMWAIT: begin
          mem_rd = (opcode == OP_LD);
          mem_wr = (opcode == OP_ST);
        end
        S_WB: begin
          reg_we = 1'b1;
          wb_sel = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed-vector bench for cpu_ctrl_fsm; each expected output word is hand-derived
// as {state, pc_ld, pc_inc, ir_ld, mem_rd, mem_wr, reg_we, wb_sel, alu_op, halted, err}.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir_in;
  logic        zero;
  logic        mem_rdy;
  logic        pc_ld, pc_inc, ir_ld, mem_rd, mem_wr, reg_we, wb_sel, halted;
  logic [2:0]  alu_op, state;
  logic [1:0]  err;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_ctrl_fsm #(.WAIT_MAX(15), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .zero(zero), .mem_rdy(mem_rdy),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_we(reg_we), .wb_sel(wb_sel), .alu_op(alu_op), .halted(halted),
    .err(err), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] I_NOP = 16'h0000, I_ADD = 16'h1234, I_SUB = 16'h2abc,
                          I_LD  = 16'h3010, I_ST  = 16'h4020, I_JMP = 16'h5555,
                          I_BEQ = 16'h6001, I_ILL = 16'h9000, I_HLT = 16'hF000;

  // Expected words: state | pc_ld pc_inc ir_ld mem_rd mem_wr reg_we wb_sel | alu_op | halted | err
  localparam logic [15:0] X_RST   = {3'b000, 7'b0000000, 3'b000, 1'b0, 2'b00};
  localparam logic [15:0] X_FETCH = {3'b000, 7'b0111000, 3'b000, 1'b0, 2'b00};
  localparam logic [15:0] X_FWAIT = {3'b000, 7'b0001000, 3'b000, 1'b0, 2'b00};
  localparam logic [15:0] X_DEC   = {3'b001, 7'b0000000, 3'b000, 1'b0, 2'b00};
  localparam logic [15:0] X_ADD   = {3'b010, 7'b0000010, 3'b001, 1'b0, 2'b00};
  localparam logic [15:0] X_SUB   = {3'b010, 7'b0000010, 3'b010, 1'b0, 2'b00};
  localparam logic [15:0] X_JMP   = {3'b010, 7'b1000000, 3'b000, 1'b0, 2'b00};
  localparam logic [15:0] X_BEQT  = {3'b010, 7'b1000000, 3'b011, 1'b0, 2'b00};
  localparam logic [15:0] X_BEQN  = {3'b010, 7'b0000000, 3'b011, 1'b0, 2'b00};
  localparam logic [15:0] X_LDW   = {3'b011, 7'b0001000, 3'b000, 1'b0, 2'b00};
  localparam logic [15:0] X_STW   = {3'b011, 7'b0000100, 3'b000, 1'b0, 2'b00};
  localparam logic [15:0] X_MRST  = {3'b011, 7'b0000000, 3'b000, 1'b0, 2'b00};
  localparam logic [15:0] X_WB    = {3'b100, 7'b0000011, 3'b000, 1'b0, 2'b00};
  localparam logic [15:0] X_HLT0  = {3'b101, 7'b0000000, 3'b000, 1'b1, 2'b00};
  localparam logic [15:0] X_HLT1  = {3'b101, 7'b0000000, 3'b000, 1'b1, 2'b01};
  localparam logic [15:0] X_HLT2  = {3'b101, 7'b0000000, 3'b000, 1'b1, 2'b10};
  localparam logic [15:0] X_HRST  = {3'b101, 7'b0000000, 3'b000, 1'b0, 2'b10};

  function automatic logic [15:0] obs();
    return {state, pc_ld, pc_inc, ir_ld, mem_rd, mem_wr, reg_we, wb_sel, alu_op, halted, err};
  endfunction

  // Stimulus word: {reset, mem_rdy, zero, ir_in}
  task automatic drive(input logic [18:0] s);
    {reset, mem_rdy, zero, ir_in} = s;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Neither enable pair may ever be high together.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b1) begin
      n_cmp++;
      if ((pc_ld && pc_inc) || (mem_rd && mem_wr)) begin
        n_bad++;
        $display("FAIL invariant t=%0t: pc_ld=%b pc_inc=%b mem_rd=%b mem_wr=%b",
                 $time, pc_ld, pc_inc, mem_rd, mem_wr);
      end
    end
  end

  task automatic test_reset();
    drive({1'b0, 1'b1, 1'b0, I_ADD});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (obs() !== X_RST) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got %h expected %h", i, obs(), X_RST);
      end
    end
  endtask

  task automatic test_add();
    logic [18:0] s[4];
    logic [15:0] e[4];
    s = '{{3'b110, I_ADD}, {3'b110, I_ADD}, {3'b110, I_ADD}, {3'b110, I_ADD}};
    e = '{X_FETCH, X_DEC, X_ADD, X_FETCH};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      #1;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++;
        $display("FAIL add step%0d: got %h expected %h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    logic [18:0] s[7];
    logic [15:0] e[7];
    s = '{{3'b110, I_BEQ}, {3'b110, I_BEQ}, {3'b111, I_BEQ}, {3'b110, I_BEQ},
          {3'b111, I_BEQ}, {3'b110, I_BEQ}, {3'b110, I_BEQ}};
    e = '{X_FETCH, X_DEC, X_BEQT, X_FETCH, X_DEC, X_BEQN, X_FETCH};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      #1;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++;
        $display("FAIL beq step%0d: got %h expected %h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    logic [18:0] s[8];
    logic [15:0] e[8];
    s = '{{3'b110, I_LD}, {3'b100, I_LD}, {3'b100, I_LD}, {3'b100, I_LD},
          {3'b100, I_LD}, {3'b110, I_LD}, {3'b100, I_LD}, {3'b110, I_LD}};
    e = '{X_FETCH, X_DEC, X_LDW, X_LDW, X_LDW, X_LDW, X_WB, X_FETCH};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      #1;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++;
        $display("FAIL load step%0d: got %h expected %h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] s[12];
    logic [15:0] e[12];
    s = '{{3'b110, I_NOP}, {3'b110, I_NOP}, {3'b110, I_ST},  {3'b110, I_ST},
          {3'b110, I_ST},  {3'b110, I_JMP}, {3'b110, I_JMP}, {3'b110, I_JMP},
          {3'b110, I_SUB}, {3'b110, I_SUB}, {3'b110, I_SUB}, {3'b110, I_SUB}};
    e = '{X_FETCH, X_DEC, X_FETCH, X_DEC, X_STW, X_FETCH, X_DEC, X_JMP,
          X_FETCH, X_DEC, X_SUB, X_FETCH};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(s[i]);
      #1;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++;
        $display("FAIL b2b step%0d: got %h expected %h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    drive({3'b100, I_ADD});
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++;
      if (obs() !== X_FWAIT) begin
        n_bad++;
        $display("FAIL fetch_wait cyc%0d: got %h expected %h", i, obs(), X_FWAIT);
      end
      @(negedge clk);
    end
    drive({3'b111, I_ADD});
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (obs() !== X_HLT2) begin
        n_bad++;
        $display("FAIL fetch_timeout_halt cyc%0d: got %h expected %h", i, obs(), X_HLT2);
      end
      @(negedge clk);
    end
    drive({3'b011, I_ADD});
    #1;
    n_cmp++;
    if (obs() !== X_HRST) begin
      n_bad++;
      $display("FAIL halt_in_reset: got %h expected %h", obs(), X_HRST);
    end
    @(negedge clk);
    drive({3'b100, I_ADD});
    #1;
    n_cmp++;
    if (obs() !== X_FWAIT) begin
      n_bad++;
      $display("FAIL err_cleared: got %h expected %h", obs(), X_FWAIT);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_boundary();
    do_reset();
    drive({3'b100, I_NOP});
    for (int i = 0; i < 15; i++) begin
      #1;
      n_cmp++;
      if (obs() !== X_FWAIT) begin
        n_bad++;
        $display("FAIL boundary_wait cyc%0d: got %h expected %h", i, obs(), X_FWAIT);
      end
      @(negedge clk);
    end
    drive({3'b110, I_NOP});
    #1;
    n_cmp++;
    if (obs() !== X_FETCH) begin
      n_bad++;
      $display("FAIL boundary_rdy: got %h expected %h", obs(), X_FETCH);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs() !== X_DEC) begin
      n_bad++;
      $display("FAIL boundary_decode: got %h expected %h", obs(), X_DEC);
    end
    @(negedge clk);
  endtask

  task automatic test_mem_timeout();
    do_reset();
    drive({3'b110, I_ST});
    #1;
    n_cmp++;
    if (obs() !== X_FETCH) begin
      n_bad++;
      $display("FAIL st_fetch: got %h expected %h", obs(), X_FETCH);
    end
    @(negedge clk);
    drive({3'b100, I_ST});
    for (int i = 0; i < 18; i++) begin
      logic [15:0] x;
      x = (i == 0) ? X_DEC : (i < 17) ? X_STW : X_HLT2;
      #1;
      n_cmp++;
      if (obs() !== x) begin
        n_bad++;
        $display("FAIL mem_timeout cyc%0d: got %h expected %h", i, obs(), x);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt_ops(input logic [15:0] ir, input logic [15:0] xh);
    do_reset();
    drive({3'b110, ir});
    for (int i = 0; i < 12; i++) begin
      logic [15:0] x;
      x = (i == 0) ? X_FETCH : (i == 1) ? X_DEC : xh;
      if (i >= 2) drive({3'b111, ir});
      #1;
      n_cmp++;
      if (obs() !== x) begin
        n_bad++;
        $display("FAIL halt_op %h cyc%0d: got %h expected %h", ir, i, obs(), x);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    drive({3'b110, I_ST});
    #1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs() !== X_DEC) begin
      n_bad++;
      $display("FAIL abort_decode: got %h expected %h", obs(), X_DEC);
    end
    @(negedge clk);
    drive({3'b010, I_ST});
    #1;
    n_cmp++;
    if (obs() !== X_MRST) begin
      n_bad++;
      $display("FAIL abort_memwait: got %h expected %h", obs(), X_MRST);
    end
    @(negedge clk);
    drive({3'b100, I_ST});
    for (int i = 0; i < 17; i++) begin
      logic [15:0] x;
      x = (i < 16) ? X_FWAIT : X_HLT2;
      #1;
      n_cmp++;
      if (obs() !== x) begin
        n_bad++;
        $display("FAIL abort_refetch cyc%0d: got %h expected %h", i, obs(), x);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq();
    test_load();
    test_back_to_back();
    test_fetch_timeout();
    test_wait_boundary();
    test_mem_timeout();
    test_halt_ops(I_ILL, X_HLT1);
    test_halt_ops(I_HLT, X_HLT0);
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
